alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Downstream golden-model checker for the registered 4-bit ALU; consumes the same operand/opcode stream the ALU receives plus the ALU's registered outputs.
- Delays each issued vector to align with the ALU's 1-cycle output latency, recomputes the expected result/carry/zero, and compares.
- Counts vectors and mismatches, pulses a per-vector mismatch, and raises a sticky alarm at a threshold.
- Feeds the trust/detection logic and the SoC status registers.

Parameters:
- DATA_W, 4, operand/result width.
- DUT_LAT, 1, ALU output latency in cycles (legal range 1..4).
- CNT_W, 16, width of vector and error counters.
- ALARM_THRESH, 1, mismatch count at which alarm asserts (legal range 1..2^CNT_W-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  checker armed; gates acceptance of new vectors.
- clear  in  1  synchronous clear of counters, pipe, alarm and capture.
- vec_valid  in  1  operands on vec_a/vec_b/vec_op were issued to the ALU this cycle.
- vec_a  in  DATA_W  operand A issued.
- vec_b  in  DATA_W  operand B issued.
- vec_op  in  2  opcode issued (00 ADD, 01 SUB, 10 AND, 11 OR).
- dut_result  in  DATA_W  ALU registered result.
- dut_carry  in  1  ALU registered carry_out.
- dut_zero  in  1  ALU registered zero_flag.
- chk_valid  out  1  a comparison was made this cycle.
- mismatch  out  1  one-cycle pulse: compared vector failed.
- alarm  out  1  sticky: err_count reached ALARM_THRESH.
- state  out  2  FSM state encoding.
- vec_count  out  CNT_W  vectors compared, saturating.
- err_count  out  CNT_W  mismatching vectors, saturating.
- first_err_vec  out  2*DATA_W+2  {op,a,b} of first mismatch.
- first_err_obs  out  DATA_W+2  {result,carry,zero} observed at first mismatch.

Behaviour:
- Reset: all outputs 0, state IDLE, delay pipe valid bits 0.
- Pipe: DUT_LAT-stage shift register of {valid,a,b,op}. Stage-0 valid = vec_valid & enable. The tap at depth DUT_LAT aligns with dut_* of the same vector.
- Golden model at the tap:
  - ADD: s=a+b (DATA_W+1 bits); result s[DATA_W-1:0], carry s[DATA_W].
  - SUB: d=a-b (DATA_W+1 bits, modulo); result d[DATA_W-1:0], carry d[DATA_W] (borrow).
  - AND/OR: bitwise; carry 0.
  - zero = (result==0).
- Compare when tap valid: mismatch if any of result, carry or zero differs.
- Outputs registered one cycle after the tap, so chk_valid and mismatch appear DUT_LAT+1 cycles after vec_valid.
- Counters: vec_count +1 per compare; err_count +1 per mismatch. Both saturate at all-ones with no wrap.
- FSM states:
  - IDLE(0): enable=0.
  - ARMED(1): enable=1, err_count=0.
  - ERROR(2): 0<err_count<ALARM_THRESH.
  - ALARM(3): err_count>=ALARM_THRESH.
- Transitions:
  - IDLE->ARMED on enable; ARMED->IDLE on !enable.
  - ARMED->ERROR or ALARM on mismatch, depending on updated count; ERROR->ALARM when the count reaches threshold.
  - ERROR and ALARM are left only by clear or reset; enable is ignored there.
- alarm = (state==ALARM), registered.
- enable deassert mid-stream: no new entries; in-flight entries still compared and counted.
- clear:
  - Zeroes counters, capture registers and pipe valids.
  - Deasserts alarm.
  - Next state ARMED if enable else IDLE.
  - Takes priority over a same-cycle mismatch; that mismatch is discarded and the mismatch pulse is suppressed.
- Asynchronous reset mid-operation discards the pipe entirely.

Optional Feature:
- CHK_FIRST_ERR_EN defined: on the first mismatch since reset/clear, latch first_err_vec and first_err_obs; hold them until clear/reset, and do not overwrite on later mismatches.
- Not defined: capture registers absent; both outputs tied to 0.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD/OP_SUB/OP_AND/OP_OR;
  - checker state typedef/constants S_IDLE..S_ALARM;
  - DATA_W default.
- Sub-module alu_golden_model: pure combinational {a,b,op} -> {result,carry,zero}.
  - Reusable by the stimulus bench and other checkers.

Test Plan (DUT_LAT=1, ALARM_THRESH=2):
- Clean ADD: enable=1; vec 3+4 op00; dut returns 0111/c0/z0 -> chk_valid at +2 cycles; mismatch=0; vec_count=1; state ARMED.
- Carry and zero: a=1111 b=0001 op00; dut 0000/c1/z1 -> no mismatch. SUB 0000-0001; dut 1111/c1/z0 -> no mismatch.
- Corrupted LSB: a=1111 b=1111 op00; dut 1111/c1/z0 (golden 1110) -> mismatch pulse; err_count=1; state ERROR; with CHK_FIRST_ERR_EN, first_err_vec={00,1111,1111} and first_err_obs={1111,1,0}.
- Second corruption: a=0000 b=1111 op10; dut 0001/c0/z0 -> err_count=2; alarm=1; state ALARM; first_err_* unchanged.
- clear same cycle as a mismatching compare -> mismatch=0; counters 0; alarm=0; state ARMED.
- Saturation and reset: CNT_W=4 override, 20 vectors -> vec_count=15; assert rst_n low mid-pipe -> all outputs 0 immediately, no stale compare after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its result checker: opcodes,
// checker FSM states and the default datapath width.
package alu_pkg;

  localparam int ALU_DATA_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_ERROR = 2'd2,
    S_ALARM = 2'd3
  } chk_state_t;

endpackage

// File: rtl/alu_golden_model.sv
// Pure combinational reference for the ALU: {a,b,op} -> {result,carry,zero}.
// SUB reports the borrow in carry (bit DATA_W of the modulo difference).
module alu_golden_model
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  {carry, result} = sum;
      OP_SUB:  {carry, result} = diff;
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_result_checker.sv
// Golden-model checker that delays issued ALU vectors by DUT_LAT cycles and
// compares against the ALU's registered outputs. Define CHK_FIRST_ERR_EN to keep first-mismatch capture.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int DATA_W       = ALU_DATA_W,
  parameter int DUT_LAT      = 1,
  parameter int CNT_W        = 16,
  parameter int ALARM_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  vec_valid,
  input  logic [DATA_W-1:0]     vec_a,
  input  logic [DATA_W-1:0]     vec_b,
  input  logic [1:0]            vec_op,
  input  logic [DATA_W-1:0]     dut_result,
  input  logic                  dut_carry,
  input  logic                  dut_zero,
  output logic                  chk_valid,
  output logic                  mismatch,
  output logic                  alarm,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      vec_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [2*DATA_W+1:0]   first_err_vec,
  output logic [DATA_W+1:0]     first_err_obs
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ALARM_THRESH);

  logic              pipe_valid [DUT_LAT];
  logic [DATA_W-1:0] pipe_a     [DUT_LAT];
  logic [DATA_W-1:0] pipe_b     [DUT_LAT];
  logic [1:0]        pipe_op    [DUT_LAT];

  logic              tap_valid;
  logic [DATA_W-1:0] tap_a;
  logic [DATA_W-1:0] tap_b;
  logic [1:0]        tap_op;
  logic [DATA_W-1:0] gold_result;
  logic              gold_carry;
  logic              gold_zero;
  logic              miss_now;
  logic [CNT_W-1:0]  vec_next;
  logic [CNT_W-1:0]  err_next;
  chk_state_t        state_q;
  chk_state_t        state_next;

  // Stage 0 captures the issue cycle; the last stage lines up with dut_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DUT_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_a[i]     <= '0;
        pipe_b[i]     <= '0;
        pipe_op[i]    <= '0;
      end
    end else begin
      pipe_valid[0] <= vec_valid & enable & ~clear;
      pipe_a[0]     <= vec_a;
      pipe_b[0]     <= vec_b;
      pipe_op[0]    <= vec_op;
      for (int i = 1; i < DUT_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1] & ~clear;
        pipe_a[i]     <= pipe_a[i-1];
        pipe_b[i]     <= pipe_b[i-1];
        pipe_op[i]    <= pipe_op[i-1];
      end
    end
  end

  assign tap_valid = pipe_valid[DUT_LAT-1];
  assign tap_a     = pipe_a[DUT_LAT-1];
  assign tap_b     = pipe_b[DUT_LAT-1];
  assign tap_op    = pipe_op[DUT_LAT-1];

  alu_golden_model #(.DATA_W(DATA_W)) u_golden (
    .a      (tap_a),
    .b      (tap_b),
    .op     (tap_op),
    .result (gold_result),
    .carry  (gold_carry),
    .zero   (gold_zero)
  );

  always_comb begin
    miss_now = tap_valid &
               ({gold_result, gold_carry, gold_zero} != {dut_result, dut_carry, dut_zero});
    vec_next = vec_count;
    err_next = err_count;
    if (tap_valid && vec_count != '1) vec_next = vec_count + CNT_W'(1);
    if (miss_now && err_count != '1)  err_next = err_count + CNT_W'(1);
  end

  // A mismatch from in-flight entries escalates even after enable drops.
  always_comb begin
    state_next = state_q;
    if (clear) begin
      state_next = enable ? S_ARMED : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ARMED: begin
          if (miss_now)     state_next = (err_next >= THRESH) ? S_ALARM : S_ERROR;
          else if (enable)  state_next = S_ARMED;
          else              state_next = S_IDLE;
        end
        S_ERROR: if (err_next >= THRESH) state_next = S_ALARM;
        default: state_next = S_ALARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      alarm     <= 1'b0;
      chk_valid <= 1'b0;
      mismatch  <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
    end else begin
      state_q <= state_next;
      alarm   <= (state_next == S_ALARM);
      if (clear) begin
        chk_valid <= 1'b0;
        mismatch  <= 1'b0;
        vec_count <= '0;
        err_count <= '0;
      end else begin
        chk_valid <= tap_valid;
        mismatch  <= miss_now;
        vec_count <= vec_next;
        err_count <= err_next;
      end
    end
  end

  assign state = state_q;

`ifdef CHK_FIRST_ERR_EN
  // err_count of zero marks "no mismatch yet since reset/clear".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_vec <= '0;
      first_err_obs <= '0;
    end else if (clear) begin
      first_err_vec <= '0;
      first_err_obs <= '0;
    end else if (miss_now && err_count == '0) begin
      first_err_vec <= {tap_op, tap_a, tap_b};
      first_err_obs <= {dut_result, dut_carry, dut_zero};
    end
  end
`else
  assign first_err_vec = '0;
  assign first_err_obs = '0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker (DUT_LAT=1, CNT_W=4, ALARM_THRESH=2);
// first-error capture expectations follow CHK_FIRST_ERR_EN.
module tb_alu_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic       vec_valid;
  logic [3:0] vec_a;
  logic [3:0] vec_b;
  logic [1:0] vec_op;
  logic [3:0] dut_result;
  logic       dut_carry;
  logic       dut_zero;
  logic       chk_valid;
  logic       mismatch;
  logic       alarm;
  logic [1:0] state;
  logic [3:0] vec_count;
  logic [3:0] err_count;
  logic [9:0] first_err_vec;
  logic [5:0] first_err_obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.DATA_W(4), .DUT_LAT(1), .CNT_W(4), .ALARM_THRESH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clear         (clear),
    .vec_valid     (vec_valid),
    .vec_a         (vec_a),
    .vec_b         (vec_b),
    .vec_op        (vec_op),
    .dut_result    (dut_result),
    .dut_carry     (dut_carry),
    .dut_zero      (dut_zero),
    .chk_valid     (chk_valid),
    .mismatch      (mismatch),
    .alarm         (alarm),
    .state         (state),
    .vec_count     (vec_count),
    .err_count     (err_count),
    .first_err_vec (first_err_vec),
    .first_err_obs (first_err_obs)
  );

  // Issue one vector, present the ALU response one cycle later, and return
  // #1 after the edge that registers the comparison.
  task automatic send_vec(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] res, input logic c, input logic z);
    @(posedge clk); #1;
    vec_valid = 1'b1; vec_a = a; vec_b = b; vec_op = op;
    @(posedge clk); #1;
    vec_valid = 1'b0; dut_result = res; dut_carry = c; dut_zero = z;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; vec_valid = 1'b0;
    vec_a = '0; vec_b = '0; vec_op = '0; dut_result = '0; dut_carry = 1'b0; dut_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({chk_valid, mismatch, alarm} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {chk_valid, mismatch, alarm}); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if ({vec_count, err_count} !== 8'h00) begin fails++; $display("FAIL reset_counts got %h want 00", {vec_count, err_count}); end
    tests++; if ({first_err_vec, first_err_obs} !== 16'h0000) begin fails++; $display("FAIL reset_capture got %h want 0000", {first_err_vec, first_err_obs}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_clean_add();
    enable = 1'b1;
    @(posedge clk); #1;
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL armed got %0d want 1", state); end
    vec_valid = 1'b1; vec_a = 4'd3; vec_b = 4'd4; vec_op = 2'b00;
    @(posedge clk); #1;
    vec_valid = 1'b0; dut_result = 4'b0111; dut_carry = 1'b0; dut_zero = 1'b0;
    tests++; if (chk_valid !== 1'b0) begin fails++; $display("FAIL add_early got %b want 0", chk_valid); end
    @(posedge clk); #1;
    tests++; if ({chk_valid, mismatch} !== 2'b10) begin fails++; $display("FAIL add_cmp got %b want 10", {chk_valid, mismatch}); end
    tests++; if (vec_count !== 4'd1) begin fails++; $display("FAIL add_count got %0d want 1", vec_count); end
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL add_state got %0d want 1", state); end
    @(posedge clk); #1;
    tests++; if (chk_valid !== 1'b0) begin fails++; $display("FAIL add_pulse got %b want 0", chk_valid); end
  endtask

  task automatic test_carry_zero();
    send_vec(4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b1);
    tests++; if ({chk_valid, mismatch} !== 2'b10) begin fails++; $display("FAIL add_carry got %b want 10", {chk_valid, mismatch}); end
    send_vec(4'b0000, 4'b0001, 2'b01, 4'b1111, 1'b1, 1'b0);
    tests++; if ({chk_valid, mismatch} !== 2'b10) begin fails++; $display("FAIL sub_borrow got %b want 10", {chk_valid, mismatch}); end
    send_vec(4'b1010, 4'b0101, 2'b11, 4'b1111, 1'b0, 1'b0);
    tests++; if ({chk_valid, mismatch} !== 2'b10) begin fails++; $display("FAIL or_clean got %b want 10", {chk_valid, mismatch}); end
    tests++; if ({vec_count, err_count} !== {4'd4, 4'd0}) begin fails++; $display("FAIL clean_counts got %h want 40", {vec_count, err_count}); end
  endtask

  task automatic test_corrupt_lsb();
    send_vec(4'b1111, 4'b1111, 2'b00, 4'b1111, 1'b1, 1'b0);
    tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL lsb_mismatch got %b want 1", mismatch); end
    tests++; if ({vec_count, err_count} !== {4'd5, 4'd1}) begin fails++; $display("FAIL lsb_counts got %h want 51", {vec_count, err_count}); end
    tests++; if ({state, alarm} !== {2'd2, 1'b0}) begin fails++; $display("FAIL lsb_state got %b want 100", {state, alarm}); end
`ifdef CHK_FIRST_ERR_EN
    tests++; if ({first_err_vec, first_err_obs} !== {10'b00_1111_1111, 6'b1111_1_0}) begin fails++; $display("FAIL lsb_capture got %h want %h", {first_err_vec, first_err_obs}, {10'b00_1111_1111, 6'b1111_1_0}); end
`else
    tests++; if ({first_err_vec, first_err_obs} !== 16'h0000) begin fails++; $display("FAIL lsb_capture got %h want 0000", {first_err_vec, first_err_obs}); end
`endif
    @(posedge clk); #1;
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL lsb_pulse got %b want 0", mismatch); end
  endtask

  task automatic test_second_corruption();
    send_vec(4'b0000, 4'b1111, 2'b10, 4'b0001, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL and_mismatch got %b want 1", mismatch); end
    tests++; if (err_count !== 4'd2) begin fails++; $display("FAIL and_errs got %0d want 2", err_count); end
    tests++; if ({state, alarm} !== {2'd3, 1'b1}) begin fails++; $display("FAIL alarm_state got %b want 111", {state, alarm}); end
`ifdef CHK_FIRST_ERR_EN
    tests++; if ({first_err_vec, first_err_obs} !== {10'b00_1111_1111, 6'b1111_1_0}) begin fails++; $display("FAIL capture_hold got %h want %h", {first_err_vec, first_err_obs}, {10'b00_1111_1111, 6'b1111_1_0}); end
`endif
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({state, alarm} !== {2'd3, 1'b1}) begin fails++; $display("FAIL alarm_sticky got %b want 111", {state, alarm}); end
    enable = 1'b1;
  endtask

  task automatic test_clear_priority();
    @(posedge clk); #1;
    vec_valid = 1'b1; vec_a = 4'd1; vec_b = 4'd1; vec_op = 2'b00;
    @(posedge clk); #1;
    vec_valid = 1'b0; dut_result = 4'd3; dut_carry = 1'b0; dut_zero = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL clear_mismatch got %b want 0", mismatch); end
    tests++; if ({vec_count, err_count} !== 8'h00) begin fails++; $display("FAIL clear_counts got %h want 00", {vec_count, err_count}); end
    tests++; if ({state, alarm} !== {2'd1, 1'b0}) begin fails++; $display("FAIL clear_state got %b want 010", {state, alarm}); end
    tests++; if ({first_err_vec, first_err_obs} !== 16'h0000) begin fails++; $display("FAIL clear_capture got %h want 0000", {first_err_vec, first_err_obs}); end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    vec_a = 4'd0; vec_b = 4'd0; vec_op = 2'b10;
    dut_result = 4'd0; dut_carry = 1'b0; dut_zero = 1'b1;
    vec_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    vec_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (vec_count !== 4'd15) begin fails++; $display("FAIL sat_count got %0d want 15", vec_count); end
    tests++; if ({err_count, state} !== {4'd0, 2'd1}) begin fails++; $display("FAIL sat_clean got %h want 01", {err_count, state}); end
  endtask

  task automatic test_reset_mid_pipe();
    @(posedge clk); #1;
    vec_valid = 1'b1; vec_a = 4'd2; vec_b = 4'd2; vec_op = 2'b00;
    @(posedge clk); #1;
    vec_valid = 1'b0; dut_result = 4'd9; dut_carry = 1'b1; dut_zero = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if ({chk_valid, mismatch, alarm, state} !== 5'b0) begin fails++; $display("FAIL rst_async got %b want 00000", {chk_valid, mismatch, alarm, state}); end
    tests++; if ({vec_count, err_count} !== 8'h00) begin fails++; $display("FAIL rst_counts got %h want 00", {vec_count, err_count}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if ({chk_valid, mismatch, err_count} !== 6'b0) begin fails++; $display("FAIL rst_stale cycle %0d got %b want 0", i, {chk_valid, mismatch, err_count}); end
    end
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL rst_rearm got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_clean_add();
    test_carry_zero();
    test_corrupt_lsb();
    test_second_corruption();
    test_clear_priority();
    test_saturation();
    test_reset_mid_pipe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
